// File: rtl/sipo_frame_rx.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx
//
// Purpose:
//   Serial frame receiver fed by the serial output of an upstream delay line.
//   It waits for a start bit (1) and shifts in DATA_W data bits, LSB first.
//   When PARITY_EN is set it then takes an even-parity bit, and it finishes
//   with a stop bit (0). A good frame is presented in parallel on dout together
//   with a one-cycle dout_valid pulse. A bad frame is discarded and flagged
//   with a one-cycle parity_err or frame_err pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   si         in   serial line (idle level 0)
//   en         in   bit strobe; si is consumed only on edges where en=1
//   dout       out  last good received word (held until the next good frame)
//   dout_valid out  one-cycle pulse: dout has just been updated
//   parity_err out  one-cycle pulse: parity mismatch, frame discarded
//   frame_err  out  one-cycle pulse: stop bit was 1, frame discarded
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module sipo_frame_rx #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              si,
    input  logic              en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // The counter only has to reach DATA_W-1.
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RESYNC
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    always_comb begin
        // Datapath holds by default. The pulses default to 0, so they clear on
        // every edge whether or not en is high.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (si) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end

                ST_DATA: begin
                    // Right shift: the first (LSB) bit ends up at bit 0 once
                    // DATA_W bits have been taken in.
                    shift_d = {si, shift_q[DATA_W-1:1]};
                    par_d   = par_q ^ si;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end

                ST_PARITY: begin
                    par_d   = par_q ^ si;
                    state_d = ST_STOP;
                end

                ST_STOP: begin
                    if (si) begin
                        // A framing error hides any parity result for this frame.
                        ferr_d  = 1'b1;
                        state_d = ST_RESYNC;
                    end else if (PARITY_EN && par_q) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                ST_RESYNC: begin
                    // Wait for the line to drop so that a stuck-high line is
                    // never read as a fresh start bit.
                    if (!si) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       si_a, en_a, si_b, en_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, perr_a, ferr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, busy_b;

    always #5 clk = ~clk;

    // Instance A: defaults (8 data bits, even parity).
    sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .si         (si_a),
        .en         (en_a),
        .dout       (dout_a),
        .dout_valid (valid_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .busy       (busy_a)
    );

    // Instance B: no parity bit.
    sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .si         (si_b),
        .en         (en_b),
        .dout       (dout_b),
        .dout_valid (valid_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .busy       (busy_b)
    );

    // Expected pulse kind is one-hot {dout_valid, parity_err, frame_err}.
    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] model_dout_a, model_dout_b;

    int checks = 0;
    int passed = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: on every output pulse, pop the next expected event and compare.
    always @(negedge clk) begin
        exp_t e;
        if (valid_a | perr_a | ferr_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", {29'd0, valid_a, perr_a, ferr_a}, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_pulse_kind", {29'd0, valid_a, perr_a, ferr_a}, {29'd0, e.kind});
                check("a_dout", {24'd0, dout_a}, {24'd0, e.data});
                $display("A event kind=%b dout=0x%02h", {valid_a, perr_a, ferr_a}, dout_a);
            end
        end
        if (valid_b | perr_b | ferr_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", {29'd0, valid_b, perr_b, ferr_b}, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_pulse_kind", {29'd0, valid_b, perr_b, ferr_b}, {29'd0, e.kind});
                check("b_dout", {24'd0, dout_b}, {24'd0, e.data});
                $display("B event kind=%b dout=0x%02h", {valid_b, perr_b, ferr_b}, dout_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic b, input logic e);
        if (sel == 0) begin
            si_a = b;
            en_a = e;
        end else begin
            si_b = b;
            en_b = e;
        end
    endtask

    // One bit on one enabled edge, followed by period-1 disabled edges.
    task automatic send_bit(input int sel, input logic b, input int period);
        drive(sel, b, 1'b1);
        tick();
        drive(sel, 1'b0, 1'b0);
        repeat (period - 1) tick();
    endtask

    // Full frame: start, data LSB first, parity (instance A only), stop.
    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par_flip, input logic stop,
                              input int period);
        exp_t e;
        logic pbit;
        logic pulse;
        logic bsy;
        pbit = (^data) ^ par_flip;

        drive(sel, 1'b1, 1'b1);
        tick();
        bsy = (sel == 0) ? busy_a : busy_b;
        check("busy_after_start", {31'd0, bsy}, 32'd1);
        drive(sel, 1'b0, 1'b0);
        repeat (period - 1) tick();

        for (int i = 0; i < 8; i++) send_bit(sel, data[i], period);
        if (sel == 0) send_bit(sel, pbit, period);

        // Push the expected outcome before the stop bit is issued.
        if (stop) begin
            e.kind = K_FERR;
        end else if (sel == 0 && par_flip) begin
            e.kind = K_PERR;
        end else begin
            e.kind = K_VALID;
            if (sel == 0) model_dout_a = data;
            else model_dout_b = data;
        end
        e.data = (sel == 0) ? model_dout_a : model_dout_b;
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);

        drive(sel, stop, 1'b1);
        tick();
        // Outputs must be visible right after the edge that sampled the stop bit.
        pulse = (sel == 0) ? (valid_a | perr_a | ferr_a) : (valid_b | perr_b | ferr_b);
        bsy   = (sel == 0) ? busy_a : busy_b;
        check("pulse_after_stop", {31'd0, pulse}, 32'd1);
        check("busy_after_stop", {31'd0, bsy}, {31'd0, stop});
        $display("frame sel=%0d data=0x%02h par_flip=%0d stop=%0d", sel, data, par_flip, stop);
        drive(sel, stop, 1'b0);
        repeat (period - 1) tick();
    endtask

    initial begin
        logic any_activity;
        rst_n = 1'b0;
        si_a = 1'b0; en_a = 1'b0; si_b = 1'b0; en_b = 1'b0;
        model_dout_a = 8'h00;
        model_dout_b = 8'h00;

        // 1. Reset, then idle line.
        repeat (2) tick();
        check("reset_dout_a", {24'd0, dout_a}, 32'd0);
        check("reset_busy_a", {31'd0, busy_a}, 32'd0);
        rst_n = 1'b1;
        en_a = 1'b1;
        si_a = 1'b0;
        any_activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_activity = any_activity | busy_a | valid_a | perr_a | ferr_a;
        end
        check("idle_quiet_a", {31'd0, any_activity}, 32'd0);
        check("idle_dout_a", {24'd0, dout_a}, 32'd0);
        $display("idle 20 cycles done");

        // 2. Good frame 0xA5.
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1);

        // 3. 0x3C with wrong parity, then correct.
        send_frame(0, 8'h3C, 1'b1, 1'b0, 1);
        check("dout_kept_after_perr", {24'd0, dout_a}, 32'h000000A5);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1);

        // 4. Framing error, stuck-high line, then recovery.
        send_frame(0, 8'h01, 1'b0, 1'b1, 1);
        any_activity = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(0, 1'b1, 1);
            any_activity = any_activity & busy_a;
        end
        check("resync_busy", {31'd0, any_activity}, 32'd1);
        send_bit(0, 1'b0, 1);
        check("resync_to_idle", {31'd0, busy_a}, 32'd0);
        check("dout_kept_after_ferr", {24'd0, dout_a}, 32'h0000003C);
        send_frame(0, 8'h80, 1'b0, 1'b0, 1);

        // 5. Slow strobe, reset after the 6th data bit, then a full frame.
        send_bit(0, 1'b1, 4);
        for (int i = 0; i < 6; i++) send_bit(0, (i == 1 || i == 3 || i == 4), 4); // 0x5A bits
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midframe_reset_dout", {24'd0, dout_a}, 32'd0);
        check("midframe_reset_busy", {31'd0, busy_a}, 32'd0);
        model_dout_a = 8'h00;
        model_dout_b = 8'h00;
        repeat (3) tick();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 4);
        $display("slow strobe frame done");

        // 6. No-parity instance: back-to-back frames, 20 bits total.
        send_frame(1, 8'hFF, 1'b0, 1'b0, 1);
        send_frame(1, 8'h00, 1'b0, 1'b0, 1);

        repeat (4) tick();
        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);
        check("final_dout_a", {24'd0, dout_a}, 32'h0000005A);
        check("final_dout_b", {24'd0, dout_b}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial frame receiver. Sits directly downstream of the 4-bit serial-in/serial-out delay line and consumes its serial output `so`.
- Detects a start bit and shifts in a fixed-width data word, LSB first.
- Optionally checks even parity, then checks the stop bit.
- Presents the recovered word in parallel with a one-cycle valid pulse, or flags a parity or framing error.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).
- PARITY_EN, 1. When 1, an even-parity bit follows the data bits. When 0, there is no parity bit.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- si  input  1  serial line in; connects to upstream `so`. Idle level 0.
- en  input  1  bit strobe. `si` is sampled only on rising clk edges where en=1.
- dout  output  DATA_W  last good received word.
- dout_valid  output  1  one-clk pulse: dout has just been updated.
- parity_err  output  1  one-clk pulse: parity mismatch, frame discarded.
- frame_err  output  1  one-clk pulse: stop bit was 1, frame discarded.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Frame format on si, one bit per enabled edge, in this order:
  - start bit = 1;
  - DATA_W data bits, LSB first;
  - parity bit, only if PARITY_EN;
  - stop bit = 0.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; shift register, bit counter and parity accumulator cleared.
  - dout=0, dout_valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame silently; no error pulse.
- rst_n has priority over en and over every state transition.
- FSM (transitions only on edges with en=1 unless noted):
  - IDLE: si=1 → DATA; bit counter=0, parity accumulator=0. si=0 → stay.
  - DATA: shift si into the MSB of the shift register (right shift), so after DATA_W bits the LSB-first word is aligned. XOR si into the accumulator and increment the counter. After the DATA_W-th bit → PARITY if PARITY_EN, else STOP.
  - PARITY: XOR si into the accumulator → STOP.
  - STOP, si=0 and accumulator=0 (or PARITY_EN=0): dout ← shift register, dout_valid pulses → IDLE.
  - STOP, si=0 and accumulator=1: parity_err pulses, dout unchanged → IDLE.
  - STOP, si=1: frame_err pulses, dout unchanged → RESYNC. A framing error takes precedence; no parity_err is reported for that frame.
  - RESYNC: si=0 → IDLE; si=1 → stay. A stuck-high line is never taken as a new start bit.
- Latency and pulse rules:
  - dout, dout_valid, parity_err and frame_err are registered. They update on the same clk edge that samples the stop bit, so they are visible in the following cycle.
  - Each pulse lasts exactly one clk cycle and is cleared on the next clk edge, regardless of en.
- en=0 edges: state, counter, shift register and accumulator hold; pending pulses still clear.
- Back-to-back frames: a start bit on the enabled edge immediately after the stop bit is accepted. IDLE checks si on that edge, so there is no dead bit.
- dout holds its value until the next good frame; it is never cleared except by reset.
- Frame length: total enabled edges per frame = DATA_W + 2 + PARITY_EN (11 at defaults).

Test Plan (DATA_W=8, PARITY_EN=1 unless stated; en=1 every cycle unless stated):
1. Reset, then si=0 for 20 cycles → dout=0x00; busy, dout_valid, parity_err and frame_err all stay 0.
2. Send 0xA5: bits 1,1,0,1,0,0,1,0,1,0,0 (start, data LSB first, parity 0, stop 0) → on the 11th edge dout=0xA5 and dout_valid is high for exactly 1 cycle. busy is high from the 1st through 11th edge.
3. Send 0x3C with parity bit 1 (wrong; 0x3C has four ones) → parity_err 1-cycle pulse; dout keeps 0xA5; no dout_valid. Then send 0x3C with parity 0 → dout=0x3C.
4. Send 0x01 with stop bit 1, then hold si=1 for 5 more cycles, then si=0 → frame_err pulses once; no new frame starts while si=1; the next valid frame 0x80 is received correctly.
5. en asserted every 4th cycle, sending 0x5A; assert rst_n=0 for 1 cycle after the 6th data bit → no output pulse; dout=0x00 after reset. Then a full 0x5A frame → dout=0x5A, single dout_valid pulse.
6. PARITY_EN=0: frames 0xFF and 0x00 sent back-to-back with no idle bits (20 bits total) → two dout_valid pulses, on the 10th and 20th edges, with dout=0xFF then 0x00.
